// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared FSM state encoding and select constants for the 2:1 round-robin arbiter
package mux_arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/mux2_sel.sv
// mux2_sel: combinational 2:1 payload select, sel=0 picks A
module mux2_sel #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_data,
    input  logic [WIDTH-1:0] b_data,
    input  logic             sel,
    output logic [WIDTH-1:0] mux_out
);
    assign mux_out = sel ? b_data : a_data;
endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin, burst-bounded arbiter of two valid/ready sources into one registered output
module mux2_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mux_out;
    logic             can_accept, a_xfer, b_xfer, burst_end;

    mux2_sel #(.WIDTH(WIDTH)) u_sel (
        .a_data (a_data),
        .b_data (b_data),
        .sel    (sel),
        .mux_out(mux_out)
    );

    assign can_accept = !out_valid || out_ready;
    assign a_ready    = (state == GRANT_A) && can_accept;
    assign b_ready    = (state == GRANT_B) && can_accept;
    assign a_xfer     = a_valid && a_ready;
    assign b_xfer     = b_valid && b_ready;
    assign burst_end  = cnt == CW'(BURST - 1);
    assign busy       = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sel       <= SEL_B;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (a_xfer || b_xfer) begin
                out_data  <= mux_out;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // on a tie the side that was not selected last wins
                    if (a_valid && (!b_valid || sel == SEL_B)) begin
                        state <= GRANT_A;
                        sel   <= SEL_A;
                    end else if (b_valid) begin
                        state <= GRANT_B;
                        sel   <= SEL_B;
                    end
                end
                GRANT_A: begin
                    if (a_xfer && burst_end) begin
                        cnt <= '0;
                        if (b_valid) begin
                            state <= GRANT_B;
                            sel   <= SEL_B;
                        end
                    end else if (!a_valid) begin
                        cnt <= '0;
                        if (b_valid) begin
                            state <= GRANT_B;
                            sel   <= SEL_B;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(a_xfer);
                    end
                end
                GRANT_B: begin
                    if (b_xfer && burst_end) begin
                        cnt <= '0;
                        if (a_valid) begin
                            state <= GRANT_A;
                            sel   <= SEL_A;
                        end
                    end else if (!b_valid) begin
                        cnt <= '0;
                        if (a_valid) begin
                            state <= GRANT_A;
                            sel   <= SEL_A;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(b_xfer);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
